control_sequencer: RTL

Hardwired Mini SRC control unit that drives every strobe of the single-bus datapath. It steps through a fixed fetch sequence and a per-opcode execute sequence, decoding the instruction register and the branch condition flip-flop that the datapath returns. It is the controlling end of the datapath's control interface: the datapath consumes these strobes, and this block produces them. It sits beside the datapath in the top-level CPU, together with the RAM.

---
 rtl/mini_src_pkg.sv | 68 ++++++
 rtl/control_sequencer_if.sv | 28 ++
 rtl/opcode_decoder.sv | 43 ++++
 rtl/control_sequencer.sv | 100 ++++++++++
 4 files changed

// File: rtl/mini_src_pkg.sv
// mini_src_pkg: opcode constants, sequencer states and decoded instruction types
package mini_src_pkg;
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  typedef enum logic [3:0] {
    ST_RESET, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_t;

  typedef struct packed {
    logic alu;
    logic imm;
    logic muldiv;
    logic negnot;
    logic ld;
    logic ldi;
    logic st;
    logic br;
    logic jr;
    logic jal;
    logic io_in;
    logic io_out;
    logic mfhi;
    logic mflo;
    logic nop;
    logic halt;
  } iclass_t;

  typedef struct packed {
    logic add_op;
    logic sub_op;
    logic shr_op;
    logic shl_op;
    logic ror_op;
    logic rol_op;
    logic and_op;
    logic or_op;
    logic mul_op;
    logic div_op;
    logic neg_op;
    logic not_op;
  } alu_op_t;
endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: control strobes from the sequencer and status returned by the datapath
interface control_sequencer_if;
  logic [31:0] IR_Data;
  logic ConFF_Out, Stop, Run;
  logic PC_Out, MDR_Out, ZHI_Out, ZLO_Out, HI_Out, LO_Out, C_Out, InPort_Out;
  logic PC_In, MDR_In, MAR_In, IR_In, Y_In, ZHI_In, ZLO_In, HI_In, LO_In, InPort_In, OutPort_In, ConFF_In;
  logic ADD, SUB, SHR, SHL, ROR, ROL, AND, OR, MUL, DIV, NEG, NOT;
  logic G_RA, G_RB, G_RC, R_In, R_Out, BA_Out;
  logic Read, Write, IncPC;
  modport master (
    input IR_Data, ConFF_Out, Stop,
    output Run,
    output PC_Out, MDR_Out, ZHI_Out, ZLO_Out, HI_Out, LO_Out, C_Out, InPort_Out,
    output PC_In, MDR_In, MAR_In, IR_In, Y_In, ZHI_In, ZLO_In, HI_In, LO_In, InPort_In, OutPort_In, ConFF_In,
    output ADD, SUB, SHR, SHL, ROR, ROL, AND, OR, MUL, DIV, NEG, NOT,
    output G_RA, G_RB, G_RC, R_In, R_Out, BA_Out,
    output Read, Write, IncPC
  );
  modport slave (
    output IR_Data, ConFF_Out, Stop,
    input Run,
    input PC_Out, MDR_Out, ZHI_Out, ZLO_Out, HI_Out, LO_Out, C_Out, InPort_Out,
    input PC_In, MDR_In, MAR_In, IR_In, Y_In, ZHI_In, ZLO_In, HI_In, LO_In, InPort_In, OutPort_In, ConFF_In,
    input ADD, SUB, SHR, SHL, ROR, ROL, AND, OR, MUL, DIV, NEG, NOT,
    input G_RA, G_RB, G_RC, R_In, R_Out, BA_Out,
    input Read, Write, IncPC
  );
endinterface

// File: rtl/opcode_decoder.sv
// opcode_decoder: opcode to one-hot instruction class and one-hot ALU operation
module opcode_decoder
  import mini_src_pkg::*;
(
  input  logic [4:0] opcode,
  output iclass_t    iclass,
  output alu_op_t    alu_op
);
  // undefined opcodes fall into the nop class
  always_comb begin
    iclass = '0;
    alu_op = '0;
    case (opcode)
      OP_LD:   iclass.ld = 1'b1;
      OP_LDI:  iclass.ldi = 1'b1;
      OP_ST:   iclass.st = 1'b1;
      OP_ADD:  begin iclass.alu = 1'b1; alu_op.add_op = 1'b1; end
      OP_SUB:  begin iclass.alu = 1'b1; alu_op.sub_op = 1'b1; end
      OP_SHR:  begin iclass.alu = 1'b1; alu_op.shr_op = 1'b1; end
      OP_SHL:  begin iclass.alu = 1'b1; alu_op.shl_op = 1'b1; end
      OP_ROR:  begin iclass.alu = 1'b1; alu_op.ror_op = 1'b1; end
      OP_ROL:  begin iclass.alu = 1'b1; alu_op.rol_op = 1'b1; end
      OP_AND:  begin iclass.alu = 1'b1; alu_op.and_op = 1'b1; end
      OP_OR:   begin iclass.alu = 1'b1; alu_op.or_op = 1'b1; end
      OP_ADDI: begin iclass.imm = 1'b1; alu_op.add_op = 1'b1; end
      OP_ANDI: begin iclass.imm = 1'b1; alu_op.and_op = 1'b1; end
      OP_ORI:  begin iclass.imm = 1'b1; alu_op.or_op = 1'b1; end
      OP_MUL:  begin iclass.muldiv = 1'b1; alu_op.mul_op = 1'b1; end
      OP_DIV:  begin iclass.muldiv = 1'b1; alu_op.div_op = 1'b1; end
      OP_NEG:  begin iclass.negnot = 1'b1; alu_op.neg_op = 1'b1; end
      OP_NOT:  begin iclass.negnot = 1'b1; alu_op.not_op = 1'b1; end
      OP_BR:   iclass.br = 1'b1;
      OP_JR:   iclass.jr = 1'b1;
      OP_JAL:  iclass.jal = 1'b1;
      OP_IN:   iclass.io_in = 1'b1;
      OP_OUT:  iclass.io_out = 1'b1;
      OP_MFHI: iclass.mfhi = 1'b1;
      OP_MFLO: iclass.mflo = 1'b1;
      OP_HALT: iclass.halt = 1'b1;
      default: iclass.nop = 1'b1;
    endcase
  end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Mini SRC Moore control unit driving the datapath strobes
module control_sequencer
  import mini_src_pkg::*;
(
  input  logic                Clock,
  input  logic                Clear,
  control_sequencer_if.master bus
);
  state_t  state, next_state;
  iclass_t ic;
  alu_op_t op;
  logic    t0, t1, t2, t3, t4, t5, t6, t7;
  logic    last, alu_step, addr_add, addr_calc;

  opcode_decoder u_dec (
    .opcode (bus.IR_Data[31:27]),
    .iclass (ic),
    .alu_op (op)
  );

  assign t0 = state == ST_T0;
  assign t1 = state == ST_T1;
  assign t2 = state == ST_T2;
  assign t3 = state == ST_T3;
  assign t4 = state == ST_T4;
  assign t5 = state == ST_T5;
  assign t6 = state == ST_T6;
  assign t7 = state == ST_T7;

  // state register; Clear forces RESET at the next edge
  always_ff @(posedge Clock)
    state <= Clear ? ST_RESET : next_state;

  // step sequencing; Stop is honoured only on an instruction's final step
  always_comb begin
    last = (t3 & (ic.jr | ic.io_in | ic.io_out | ic.mfhi | ic.mflo | ic.nop)) |
           (t4 & (ic.negnot | ic.jal)) |
           (t5 & (ic.alu | ic.imm | ic.ldi)) |
           (t6 & (ic.muldiv | ic.br)) | t7;
    next_state = (state == ST_RESET) ? ST_T0 :
                 (state == ST_HALT) ? ST_HALT :
                 (t3 & ic.halt) ? ST_HALT :
                 last ? (bus.Stop ? ST_HALT : ST_T0) :
                 state_t'(state + 4'd1);
  end

  // strobes as a function of step, instruction class and branch condition
  always_comb begin
    alu_step       = ((ic.alu | ic.imm | ic.muldiv) & t4) | (ic.negnot & t3);
    addr_calc      = ic.ld | ic.ldi | ic.st;
    addr_add       = (addr_calc & t4) | (ic.br & t5);
    bus.Run        = (state != ST_RESET) & (state != ST_HALT);
    bus.PC_Out     = t0 | (ic.br & t4) | (ic.jal & t3);
    bus.MDR_Out    = t2 | (ic.ld & t7);
    bus.ZHI_Out    = ic.muldiv & t6;
    bus.ZLO_Out    = ((ic.alu | ic.imm | ic.muldiv | addr_calc) & t5) | (ic.negnot & t4) |
                     (ic.br & t6 & bus.ConFF_Out);
    bus.HI_Out     = ic.mfhi & t3;
    bus.LO_Out     = ic.mflo & t3;
    bus.C_Out      = ((ic.imm | addr_calc) & t4) | (ic.br & t5);
    bus.InPort_Out = ic.io_in & t3;
    bus.PC_In      = (ic.br & t6 & bus.ConFF_Out) | (ic.jr & t3) | (ic.jal & t4);
    bus.MDR_In     = t1 | ((ic.ld | ic.st) & t6);
    bus.MAR_In     = t0 | ((ic.ld | ic.st) & t5);
    bus.IR_In      = t2;
    bus.Y_In       = ((ic.alu | ic.imm | ic.muldiv | addr_calc) & t3) | (ic.br & t4);
    bus.ZHI_In     = ic.muldiv & t4;
    bus.ZLO_In     = alu_step | addr_add;
    bus.HI_In      = ic.muldiv & t6;
    bus.LO_In      = ic.muldiv & t5;
    bus.InPort_In  = 1'b0;
    bus.OutPort_In = ic.io_out & t3;
    bus.ConFF_In   = ic.br & t3;
    bus.ADD        = (alu_step & op.add_op) | addr_add;
    bus.SUB        = alu_step & op.sub_op;
    bus.SHR        = alu_step & op.shr_op;
    bus.SHL        = alu_step & op.shl_op;
    bus.ROR        = alu_step & op.ror_op;
    bus.ROL        = alu_step & op.rol_op;
    bus.AND        = alu_step & op.and_op;
    bus.OR         = alu_step & op.or_op;
    bus.MUL        = alu_step & op.mul_op;
    bus.DIV        = alu_step & op.div_op;
    bus.NEG        = alu_step & op.neg_op;
    bus.NOT        = alu_step & op.not_op;
    bus.G_RA       = ((ic.alu | ic.imm | ic.ldi) & t5) | (ic.muldiv & t3) | (ic.negnot & t4) |
                     (ic.ld & t7) | (ic.st & t6) | (ic.jal & t4) |
                     ((ic.br | ic.jr | ic.io_in | ic.io_out | ic.mfhi | ic.mflo) & t3);
    bus.G_RB       = ((ic.alu | ic.imm | ic.negnot | addr_calc | ic.jal) & t3) | (ic.muldiv & t4);
    bus.G_RC       = ic.alu & t4;
    bus.R_In       = ((ic.alu | ic.imm | ic.ldi) & t5) | (ic.negnot & t4) | (ic.ld & t7) |
                     ((ic.jal | ic.io_in | ic.mfhi | ic.mflo) & t3);
    bus.R_Out      = ((ic.alu | ic.imm | ic.muldiv | ic.negnot | ic.br | ic.jr | ic.io_out) & t3) |
                     ((ic.alu | ic.muldiv | ic.jal) & t4) | (ic.st & t6);
    bus.BA_Out     = addr_calc & t3;
    bus.Read       = t1 | (ic.ld & t6);
    bus.Write      = ic.st & t7;
    bus.IncPC      = t0;
  end
endmodule
